// File: rtl/fixed_point_divider_if.sv
// Operand/result bus for the fixed-point divider. The requester side drives the
// operands and accepts results; the divider side does the reverse.
interface fixed_point_divider_if #(
    parameter int A_WORD_LEN = 9,
    parameter int B_WORD_LEN = 9,
    parameter int C_WORD_LEN = 10
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [A_WORD_LEN-1:0]  a;
    logic signed [B_WORD_LEN-1:0]  b;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [C_WORD_LEN-1:0]  c;
    logic                          overflow;
    logic                          div_by_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, overflow, div_by_zero
    );
endinterface

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider c = a / b. Divides magnitudes with a
// radix-2 restoring loop (one quotient bit per clock), then applies the sign,
// truncating toward zero and saturating into format C.
module fixed_point_divider #(
    parameter int A_FRAC_LEN = 8,
    parameter int A_WORD_LEN = 9,
    parameter int B_FRAC_LEN = 8,
    parameter int B_WORD_LEN = 9,
    parameter int C_FRAC_LEN = 8,
    parameter int C_WORD_LEN = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    fixed_point_divider_if.slave   bus
);
    // Dividend pre-shift that aligns the quotient binary point to format C.
    localparam int SHIFT = B_FRAC_LEN - A_FRAC_LEN + C_FRAC_LEN;
    localparam int ITER  = A_WORD_LEN + SHIFT;
    localparam int CNT_W = $clog2(ITER + 1);
    // Remainder needs one bit above |b| so the shifted value never wraps.
    localparam int RW    = B_WORD_LEN + 1;
    // Wide enough to compare the quotient against the format-C limits.
    localparam int QW    = ((ITER > C_WORD_LEN) ? ITER : C_WORD_LEN) + 1;

    localparam logic [QW-1:0] MAX_POS_MAG = QW'((64'd1 << (C_WORD_LEN - 1)) - 64'd1);
    localparam logic [QW-1:0] MIN_NEG_MAG = QW'(64'd1 << (C_WORD_LEN - 1));
    localparam logic signed [C_WORD_LEN-1:0] MAX_POS_C = {1'b0, {(C_WORD_LEN-1){1'b1}}};
    localparam logic signed [C_WORD_LEN-1:0] MIN_NEG_C = {1'b1, {(C_WORD_LEN-1){1'b0}}};

    generate
        if (SHIFT < 0) begin : g_bad_shift
            $error("fixed_point_divider: B_FRAC_LEN - A_FRAC_LEN + C_FRAC_LEN must be >= 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude computed one bit wider so the most-negative operand is exact.
    function automatic logic [A_WORD_LEN-1:0] mag_a(input logic signed [A_WORD_LEN-1:0] v);
        logic signed [A_WORD_LEN:0] ext;
        ext = {v[A_WORD_LEN-1], v};
        if (v[A_WORD_LEN-1]) begin
            ext = -ext;
        end else begin
            ext = ext;
        end
        return ext[A_WORD_LEN-1:0];
    endfunction

    function automatic logic [B_WORD_LEN-1:0] mag_b(input logic signed [B_WORD_LEN-1:0] v);
        logic signed [B_WORD_LEN:0] ext;
        ext = {v[B_WORD_LEN-1], v};
        if (v[B_WORD_LEN-1]) begin
            ext = -ext;
        end else begin
            ext = ext;
        end
        return ext[B_WORD_LEN-1:0];
    endfunction

    state_t                         state_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [ITER-1:0]                n_q;
    logic [ITER-1:0]                quo_q;
    logic [RW-1:0]                  rem_q;
    logic [B_WORD_LEN-1:0]          bmag_q;
    logic                           sign_q;
    logic                           a_neg_q;
    logic                           dbz_q;
    logic                           in_ready_q;
    logic                           out_valid_q;
    logic signed [C_WORD_LEN-1:0]   c_q;
    logic                           overflow_q;
    logic                           div_by_zero_q;

    logic [RW-1:0]                  shifted_s;
    logic [RW:0]                    trial_s;
    logic                           trial_neg_s;
    logic [QW-1:0]                  q_ext_s;
    logic signed [C_WORD_LEN-1:0]   res_c_s;
    logic                           res_ovf_s;
    logic                           res_dz_s;

    // One restoring step: shift in the next dividend bit and trial-subtract |b|.
    always_comb begin
        shifted_s   = {rem_q[RW-2:0], n_q[ITER-1]};
        trial_s     = {1'b0, shifted_s} - {2'b00, bmag_q};
        trial_neg_s = trial_s[RW];
    end

    // Apply sign, saturation and divide-by-zero policy to the finished quotient.
    always_comb begin
        q_ext_s   = QW'(quo_q);
        res_c_s   = '0;
        res_ovf_s = 1'b0;
        res_dz_s  = 1'b0;
        if (dbz_q) begin
            res_c_s  = a_neg_q ? MIN_NEG_C : MAX_POS_C;
            res_dz_s = 1'b1;
        end else if (!sign_q) begin
            if (q_ext_s > MAX_POS_MAG) begin
                res_c_s   = MAX_POS_C;
                res_ovf_s = 1'b1;
            end else begin
                res_c_s = q_ext_s[C_WORD_LEN-1:0];
            end
        end else begin
            if (q_ext_s > MIN_NEG_MAG) begin
                res_c_s   = MIN_NEG_C;
                res_ovf_s = 1'b1;
            end else begin
                res_c_s = -q_ext_s[C_WORD_LEN-1:0];
            end
        end
    end

    // Control FSM with all datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            n_q           <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            bmag_q        <= '0;
            sign_q        <= 1'b0;
            a_neg_q       <= 1'b0;
            dbz_q         <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            c_q           <= '0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid) begin
                        sign_q     <= bus.a[A_WORD_LEN-1] ^ bus.b[B_WORD_LEN-1];
                        a_neg_q    <= bus.a[A_WORD_LEN-1];
                        dbz_q      <= (bus.b == '0);
                        bmag_q     <= mag_b(bus.b);
                        n_q        <= ITER'(mag_a(bus.a)) << SHIFT;
                        rem_q      <= '0;
                        quo_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q != CNT_W'(ITER)) begin
                        // Iteration phase: one quotient bit per cycle, MSB first.
                        rem_q <= trial_neg_s ? shifted_s : trial_s[RW-1:0];
                        quo_q <= (quo_q << 1) | ITER'(!trial_neg_s);
                        n_q   <= n_q << 1;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        // Quotient complete: latch the formatted result.
                        c_q           <= res_c_s;
                        overflow_q    <= res_ovf_s;
                        div_by_zero_q <= res_dz_s;
                        out_valid_q   <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.c           = c_q;
    assign bus.overflow    = overflow_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider with default formats (ITER = 17,
// result valid 18 edges after the accepting edge).
module tb_fixed_point_divider;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    fixed_point_divider_if #(.A_WORD_LEN(9), .B_WORD_LEN(9), .C_WORD_LEN(10)) bus ();

    fixed_point_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) for in_ready, present operands for one accepting edge.
    task automatic start_op(input logic signed [8:0] av, input logic signed [8:0] bv);
        for (int i = 0; i < 60; i++) begin
            if (bus.in_ready === 1'b1) break;
            @(posedge clk); #1;
        end
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid; 999 means it never came.
    task automatic wait_valid(output int lat);
        lat = 999;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    // Full transfer: start, wait for result, capture it, consume it.
    task automatic do_op(input logic signed [8:0] av, input logic signed [8:0] bv,
                         output int lat, output logic signed [9:0] cv,
                         output logic ov, output logic dz);
        start_op(av, bv);
        wait_valid(lat);
        cv = bus.c;
        ov = bus.overflow;
        dz = bus.div_by_zero;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.c !== 10'sd0 || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got ov=%b c=%0d ovf=%b dz=%b want 0 0 0 0",
                     bus.out_valid, bus.c, bus.overflow, bus.div_by_zero);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; logic signed [9:0] cv; logic ov, dz;
        do_op(9'sd64, 9'sd128, lat, cv, ov, dz);
        vectors++;
        if (lat !== 18) begin miscompares++; $display("FAIL basic_latency got %0d want 18", lat); end
        vectors++;
        if (cv !== 10'sd128 || ov !== 1'b0 || dz !== 1'b0) begin
            miscompares++; $display("FAIL basic_64_128 got c=%0d ovf=%b dz=%b want 128 0 0", cv, ov, dz);
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_consumed got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_signed();
        int lat; logic signed [9:0] cv; logic ov, dz;
        do_op(-9'sd192, 9'sd128, lat, cv, ov, dz);
        vectors++;
        if (cv !== -10'sd384 || ov !== 1'b0 || dz !== 1'b0) begin
            miscompares++; $display("FAIL signed_m192_128 got c=%0d ovf=%b dz=%b want -384 0 0", cv, ov, dz);
        end
        do_op(-9'sd256, 9'sd128, lat, cv, ov, dz);
        vectors++;
        if (cv !== -10'sd512 || ov !== 1'b0 || dz !== 1'b0) begin
            miscompares++; $display("FAIL signed_exact_min got c=%0d ovf=%b dz=%b want -512 0 0", cv, ov, dz);
        end
    endtask

    task automatic test_overflow();
        int lat; logic signed [9:0] cv; logic ov, dz;
        do_op(9'sd128, 9'sd64, lat, cv, ov, dz);
        vectors++;
        if (cv !== 10'sd511 || ov !== 1'b1 || dz !== 1'b0) begin
            miscompares++; $display("FAIL ovf_128_64 got c=%0d ovf=%b dz=%b want 511 1 0", cv, ov, dz);
        end
        do_op(-9'sd256, -9'sd128, lat, cv, ov, dz);
        vectors++;
        if (cv !== 10'sd511 || ov !== 1'b1 || dz !== 1'b0) begin
            miscompares++; $display("FAIL ovf_m256_m128 got c=%0d ovf=%b dz=%b want 511 1 0", cv, ov, dz);
        end
    endtask

    task automatic test_truncation();
        int lat; logic signed [9:0] cv; logic ov, dz;
        do_op(9'sd85, 9'sd255, lat, cv, ov, dz);
        vectors++;
        if (cv !== 10'sd85 || ov !== 1'b0) begin
            miscompares++; $display("FAIL trunc_pos got c=%0d ovf=%b want 85 0", cv, ov);
        end
        do_op(-9'sd85, 9'sd255, lat, cv, ov, dz);
        vectors++;
        if (cv !== -10'sd85 || ov !== 1'b0) begin
            miscompares++; $display("FAIL trunc_neg got c=%0d ovf=%b want -85 0", cv, ov);
        end
    endtask

    task automatic test_div_by_zero();
        int lat; logic signed [9:0] cv; logic ov, dz;
        do_op(9'sd100, 9'sd0, lat, cv, ov, dz);
        vectors++;
        if (cv !== 10'sd511 || ov !== 1'b0 || dz !== 1'b1) begin
            miscompares++; $display("FAIL dbz_pos got c=%0d ovf=%b dz=%b want 511 0 1", cv, ov, dz);
        end
        vectors++;
        if (lat !== 18) begin miscompares++; $display("FAIL dbz_pos_latency got %0d want 18", lat); end
        do_op(-9'sd1, 9'sd0, lat, cv, ov, dz);
        vectors++;
        if (cv !== -10'sd512 || ov !== 1'b0 || dz !== 1'b1) begin
            miscompares++; $display("FAIL dbz_neg got c=%0d ovf=%b dz=%b want -512 0 1", cv, ov, dz);
        end
        vectors++;
        if (lat !== 18) begin miscompares++; $display("FAIL dbz_neg_latency got %0d want 18", lat); end
    endtask

    task automatic test_hold();
        int lat;
        start_op(-9'sd192, 9'sd128);
        wait_valid(lat);
        vectors++;
        if (lat !== 18) begin miscompares++; $display("FAIL hold_latency got %0d want 18", lat); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.c !== -10'sd384) begin
                miscompares++;
                $display("FAIL hold_cycle%0d got ov=%b c=%0d want 1 -384", k, bus.out_valid, bus.c);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.c !== -10'sd384) begin
            miscompares++;
            $display("FAIL hold_release got ov=%b ir=%b c=%0d want 0 1 -384", bus.out_valid, bus.in_ready, bus.c);
        end
    endtask

    task automatic test_ignore_in_valid();
        int lat;
        start_op(9'sd64, 9'sd128);
        repeat (3) begin @(posedge clk); #1; end
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++; $display("FAIL busy_in_ready got %b want 0", bus.in_ready);
        end
        bus.a = 9'sd128; bus.b = 9'sd64; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.a = 9'sd0; bus.b = 9'sd0;
        lat = 999;
        for (int n = 5; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) begin lat = n; break; end
        end
        vectors++;
        if (lat !== 18 || bus.c !== 10'sd128 || bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_in_valid got lat=%0d c=%0d ovf=%b want 18 128 0", lat, bus.c, bus.overflow);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        int lat; logic signed [9:0] cv; logic ov, dz; logic seen;
        start_op(9'sd128, 9'sd64);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_calc got ir=%b ov=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++; $display("FAIL reset_no_pulse got out_valid pulse=%b want 0", seen);
        end
        do_op(9'sd64, 9'sd128, lat, cv, ov, dz);
        vectors++;
        if (cv !== 10'sd128 || ov !== 1'b0 || lat !== 18) begin
            miscompares++; $display("FAIL after_reset_op got c=%0d ovf=%b lat=%0d want 128 0 18", cv, ov, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic signed [9:0] cv;
        bus.out_ready = 1'b1;
        start_op(9'sd100, 9'sd200);
        wait_valid(lat);
        cv = bus.c;
        vectors++;
        if (cv !== 10'sd128 || lat !== 18) begin
            miscompares++; $display("FAIL b2b_first got c=%0d lat=%0d want 128 18", cv, lat);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_consume got ov=%b ir=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        start_op(-9'sd32, 9'sd16);
        wait_valid(lat);
        cv = bus.c;
        vectors++;
        if (cv !== -10'sd512 || bus.overflow !== 1'b0 || lat !== 18) begin
            miscompares++;
            $display("FAIL b2b_second got c=%0d ovf=%b lat=%0d want -512 0 18", cv, bus.overflow, lat);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = 9'sd0;
        bus.b        = 9'sd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_signed();
        test_overflow();
        test_truncation();
        test_div_by_zero();
        test_hold();
        test_ignore_in_valid();
        test_reset_mid_calc();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
